// File: rtl/cpu5_mc_controller.sv
// cpu5_mc_controller: multicycle control FSM for cpu5.
// Sequences FETCH..WB per instruction, handshakes with a shared memory
// (wait states, bounded by an optional timeout), and traps undefined ops.
// Outputs are decodes of the registered state; FETCH completion and the
// branch PC enable also look at mem_ready / zero in the same cycle.
module cpu5_mc_controller #(
    parameter int OPCODE_W = 7,
    parameter int FUNCT_W  = 7,
    parameter int ALUCTL_W = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] op,
    input  logic [2:0]          funct3,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                memwrite,
    output logic                iord,
    output logic                irwrite,
    output logic                pc_en,
    output logic [1:0]          pcsrc,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          wbsel,
    output logic                regwrite,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                illegal,
    output logic                mem_timeout
);

    // FSM encoding
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWR  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_IEXEC  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_TRAP   = 4'd11;

    // opcodes
    localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_I      = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(7'b1101111);

    // ALU control codes
    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b010);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b110);
    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000);
    localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3'b001);
    localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(3'b111);

    // Wait counter saturates at TIMEOUT; with the timeout disabled it just
    // parks at 1 so it never wraps.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : CNT_W'(1);

    logic [3:0]       state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_store;   // captured in DECODE so op may change later
    logic             in_mem;
    logic             timed_out;
    logic [ALUCTL_W-1:0] r_alu, i_alu;
    logic             r_legal, i_legal, br_legal;
    logic             unused_funct;

    // only funct[5] matters (add vs sub); the rest of funct7 is ignored
    assign unused_funct = ^funct;

    assign in_mem    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timed_out = (TIMEOUT != 0) && in_mem && !mem_ready && (wait_cnt == CNT_SAT);
    assign br_legal  = (funct3 == 3'b000) || (funct3 == 3'b001);

    // R-type and I-type ALU decode; illegal combos fall back to add and trap
    always_comb begin
        r_alu   = ALU_ADD;
        r_legal = 1'b1;
        case (funct3)
            3'b000:  r_alu = funct[5] ? ALU_SUB : ALU_ADD;
            3'b111:  r_alu = ALU_AND;
            3'b110:  r_alu = ALU_OR;
            3'b010:  r_alu = ALU_SLT;
            default: r_legal = 1'b0;
        endcase
        i_alu   = ALU_ADD;
        i_legal = 1'b1;
        case (funct3)
            3'b000:  i_alu = ALU_ADD;
            3'b111:  i_alu = ALU_AND;
            3'b110:  i_alu = ALU_OR;
            3'b010:  i_alu = ALU_SLT;
            default: i_legal = 1'b0;
        endcase
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)      state_next = S_DECODE;
                else if (timed_out) state_next = S_FETCH;
            end
            S_DECODE: begin
                if (op == OP_LOAD || op == OP_STORE) state_next = S_MEMADR;
                else if (op == OP_R)                 state_next = S_EXEC;
                else if (op == OP_I)                 state_next = S_IEXEC;
                else if (op == OP_BRANCH)            state_next = S_BRANCH;
                else if (op == OP_JAL)               state_next = S_JUMP;
                else                                 state_next = S_TRAP;
            end
            S_MEMADR: state_next = is_store ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)      state_next = S_MEMWB;
                else if (timed_out) state_next = S_FETCH;
            end
            S_MEMWR: begin
                if (mem_ready || timed_out) state_next = S_FETCH;
            end
            S_MEMWB:  state_next = S_FETCH;
            S_EXEC:   state_next = r_legal ? S_ALUWB : S_TRAP;
            S_IEXEC:  state_next = i_legal ? S_ALUWB : S_TRAP;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = br_legal ? S_FETCH : S_TRAP;
            S_JUMP:   state_next = S_FETCH;
            S_TRAP:   state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // state register and load/store flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            is_store <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) is_store <= (op == OP_STORE);
        end
    end

    // wait counter: counts stalled memory cycles, cleared on any exit
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state_next != state || timed_out) begin
            wait_cnt <= '0;
        end else if (in_mem && !mem_ready && wait_cnt != CNT_SAT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // output decode; everything is held at 0 while reset is asserted
    always_comb begin
        mem_req     = 1'b0;
        memwrite    = 1'b0;
        iord        = 1'b0;
        irwrite     = 1'b0;
        pc_en       = 1'b0;
        pcsrc       = 2'd0;
        alusrca     = 1'b0;
        alusrcb     = 2'd0;
        wbsel       = 2'd0;
        regwrite    = 1'b0;
        alucontrol  = ALU_AND;
        illegal     = 1'b0;
        mem_timeout = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alusrcb    = 2'd1;
                alucontrol = ALU_ADD;
                irwrite    = mem_ready;
                pc_en      = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = 2'd2;
                alucontrol = ALU_ADD;
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'd2;
                alucontrol = ALU_ADD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                wbsel    = 2'd1;
            end
            S_EXEC: begin
                alusrca    = 1'b1;
                alucontrol = r_alu;
            end
            S_IEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'd2;
                alucontrol = i_alu;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'd1;
                pc_en      = br_legal & (zero ^ funct3[0]);
            end
            S_JUMP: begin
                pc_en    = 1'b1;
                pcsrc    = 2'd2;
                regwrite = 1'b1;
                wbsel    = 2'd2;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
        mem_timeout = timed_out;
        if (reset) begin
            mem_req     = 1'b0;
            memwrite    = 1'b0;
            iord        = 1'b0;
            irwrite     = 1'b0;
            pc_en       = 1'b0;
            pcsrc       = 2'd0;
            alusrca     = 1'b0;
            alusrcb     = 2'd0;
            wbsel       = 2'd0;
            regwrite    = 1'b0;
            alucontrol  = '0;
            illegal     = 1'b0;
            mem_timeout = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu5_mc_controller.sv
// Bench for cpu5_mc_controller: per-cycle expected output vectors are
// queued by the stimulus process and checked by a negedge monitor.
module tb_cpu5_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic [6:0] funct = 7'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, memwrite, iord, irwrite, pc_en, alusrca, regwrite, illegal, mem_timeout;
    logic [1:0] pcsrc, alusrcb, wbsel;
    logic [2:0] alucontrol;

    cpu5_mc_controller #(.OPCODE_W(7), .FUNCT_W(7), .ALUCTL_W(3), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite), .iord(iord),
        .irwrite(irwrite), .pc_en(pc_en), .pcsrc(pcsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .wbsel(wbsel), .regwrite(regwrite), .alucontrol(alucontrol),
        .illegal(illegal), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] e;
        string       nm;
    } item_t;
    item_t q[$];

    int total = 0;
    int bad   = 0;

    // pending inputs, applied just after the next rising edge
    logic       n_rst = 1'b1, n_zero = 1'b0;
    logic [6:0] n_op = 7'b0110011, n_f7 = 7'b0;
    logic [2:0] n_f3 = 3'b000;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;

    // {mem_req,memwrite,iord,irwrite,pc_en,pcsrc,alusrca,alusrcb,wbsel,regwrite,alu,illegal,timeout}
    function automatic logic [17:0] mk(logic mr, logic mw, logic io, logic irw, logic pe,
                                       logic [1:0] ps, logic sa, logic [1:0] sb,
                                       logic [1:0] wb, logic rw, logic [2:0] alu,
                                       logic il, logic to);
        return {mr, mw, io, irw, pe, ps, sa, sb, wb, rw, alu, il, to};
    endfunction

    function automatic logic [17:0] Z();            return '0; endfunction
    function automatic logic [17:0] F(logic r);     return mk(1,0,0,r,r,0,0,1,0,0,3'b010,0,0); endfunction
    function automatic logic [17:0] FTO();          return mk(1,0,0,0,0,0,0,1,0,0,3'b010,0,1); endfunction
    function automatic logic [17:0] D();            return mk(0,0,0,0,0,0,0,2,0,0,3'b010,0,0); endfunction
    function automatic logic [17:0] MA();           return mk(0,0,0,0,0,0,1,2,0,0,3'b010,0,0); endfunction
    function automatic logic [17:0] MR();           return mk(1,0,1,0,0,0,0,0,0,0,3'b000,0,0); endfunction
    function automatic logic [17:0] MRTO();         return mk(1,0,1,0,0,0,0,0,0,0,3'b000,0,1); endfunction
    function automatic logic [17:0] MW();           return mk(1,1,1,0,0,0,0,0,0,0,3'b000,0,0); endfunction
    function automatic logic [17:0] MWB();          return mk(0,0,0,0,0,0,0,0,1,1,3'b000,0,0); endfunction
    function automatic logic [17:0] EX(logic [2:0] a);  return mk(0,0,0,0,0,0,1,0,0,0,a,0,0); endfunction
    function automatic logic [17:0] IEX(logic [2:0] a); return mk(0,0,0,0,0,0,1,2,0,0,a,0,0); endfunction
    function automatic logic [17:0] AWB();          return mk(0,0,0,0,0,0,0,0,0,1,3'b000,0,0); endfunction
    function automatic logic [17:0] BRS(logic pe);  return mk(0,0,0,0,pe,1,1,0,0,0,3'b110,0,0); endfunction
    function automatic logic [17:0] J();            return mk(0,0,0,0,1,2,0,0,2,1,3'b000,0,0); endfunction
    function automatic logic [17:0] TR();           return mk(0,0,0,0,0,0,0,0,0,0,3'b000,1,0); endfunction

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        n_op = o; n_f3 = f3; n_f7 = f7;
    endtask

    // one clock cycle: apply pending inputs after the edge, queue the expectation
    task automatic step(input logic rdy, input logic [17:0] e, input string nm);
        item_t it;
        @(posedge clk);
        #1;
        reset = n_rst; op = n_op; funct3 = n_f3; funct = n_f7; zero = n_zero; mem_ready = rdy;
        it.e = e; it.nm = nm;
        q.push_back(it);
    endtask

    // monitor: every cycle has an expected output vector
    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            logic [17:0] act;
            it  = q.pop_front();
            act = {mem_req, memwrite, iord, irwrite, pc_en, pcsrc, alusrca, alusrcb,
                   wbsel, regwrite, alucontrol, illegal, mem_timeout};
            total++;
            if (act !== it.e) begin
                bad++;
                $display("FAIL %s: got %h want %h", it.nm, act, it.e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset held 3 cycles: all outputs 0
        instr(R, 3'b000, 7'b0000000);
        repeat (3) step(1, Z(), "reset_zero");
        n_rst = 0;
        // R add
        step(1, F(1), "r_add_fetch"); step(1, D(), "r_add_decode");
        step(1, EX(3'b010), "r_add_exec"); step(1, AWB(), "r_add_wb");
        // R sub
        instr(R, 3'b000, 7'b0100000);
        step(1, F(1), "r_sub_fetch"); step(1, D(), "r_sub_decode");
        step(1, EX(3'b110), "r_sub_exec"); step(1, AWB(), "r_sub_wb");
        // R with bad funct3 -> trap after EXEC
        instr(R, 3'b011, 7'b0);
        step(1, F(1), "r_bad_fetch"); step(1, D(), "r_bad_decode");
        step(1, EX(3'b010), "r_bad_exec"); step(1, TR(), "r_bad_trap");
        // I-ALU and / slt / illegal
        instr(I, 3'b111, 7'b0);
        step(1, F(1), "i_and_fetch"); step(1, D(), "i_and_decode");
        step(1, IEX(3'b000), "i_and_exec"); step(1, AWB(), "i_and_wb");
        instr(I, 3'b010, 7'b0);
        step(1, F(1), "i_slt_fetch"); step(1, D(), "i_slt_decode");
        step(1, IEX(3'b111), "i_slt_exec"); step(1, AWB(), "i_slt_wb");
        instr(I, 3'b001, 7'b0);
        step(1, F(1), "i_bad_fetch"); step(1, D(), "i_bad_decode");
        step(1, IEX(3'b010), "i_bad_exec"); step(1, TR(), "i_bad_trap");
        // LOAD with 2 wait cycles in MEMRD
        instr(LD, 3'b010, 7'b0);
        step(1, F(1), "ld_fetch"); step(1, D(), "ld_decode"); step(1, MA(), "ld_memadr");
        step(0, MR(), "ld_memrd_w1"); step(0, MR(), "ld_memrd_w2"); step(1, MR(), "ld_memrd_done");
        step(1, MWB(), "ld_memwb");
        // STORE; op changes during MEMADR must be ignored
        instr(ST, 3'b010, 7'b0);
        step(1, F(1), "st_fetch"); step(1, D(), "st_decode");
        instr(LD, 3'b010, 7'b0);
        step(1, MA(), "st_memadr"); step(1, MW(), "st_memwr");
        // branches
        instr(BR, 3'b000, 7'b0); n_zero = 1;
        step(1, F(1), "beq_fetch"); step(1, D(), "beq_decode"); step(1, BRS(1), "beq_taken");
        instr(BR, 3'b001, 7'b0);
        step(1, F(1), "bne_fetch"); step(1, D(), "bne_decode"); step(1, BRS(0), "bne_not_taken");
        n_zero = 0;
        step(1, F(1), "bne2_fetch"); step(1, D(), "bne2_decode"); step(1, BRS(1), "bne_taken");
        instr(BR, 3'b010, 7'b0);
        step(1, F(1), "bbad_fetch"); step(1, D(), "bbad_decode");
        step(1, BRS(0), "bbad_branch"); step(1, TR(), "bbad_trap");
        // JAL
        instr(JAL, 3'b000, 7'b0);
        step(1, F(1), "jal_fetch"); step(1, D(), "jal_decode"); step(1, J(), "jal_jump");
        // undefined opcode
        instr(7'b1111111, 3'b000, 7'b0);
        step(1, F(1), "ill_fetch"); step(1, D(), "ill_decode"); step(1, TR(), "ill_trap");
        // fetch timeout on 16th stalled cycle, then counter restarts from 0
        instr(R, 3'b000, 7'b0);
        for (int k = 0; k < 15; k++) step(0, F(0), "fetch_wait");
        step(0, FTO(), "fetch_timeout");
        for (int k = 0; k < 15; k++) step(0, F(0), "fetch_wait2");
        step(1, F(1), "fetch_ready_at_limit");
        step(1, D(), "after_to_decode"); step(1, EX(3'b010), "after_to_exec");
        step(1, AWB(), "after_to_wb");
        // MEMRD timeout: no writeback, back to FETCH
        instr(LD, 3'b000, 7'b0);
        step(1, F(1), "ldto_fetch"); step(1, D(), "ldto_decode"); step(1, MA(), "ldto_memadr");
        for (int k = 0; k < 15; k++) step(0, MR(), "ldto_wait");
        step(0, MRTO(), "ldto_timeout");
        step(0, F(0), "ldto_refetch");
        // reset during a stalled store
        instr(ST, 3'b000, 7'b0);
        step(1, F(1), "strst_fetch"); step(1, D(), "strst_decode"); step(1, MA(), "strst_memadr");
        step(0, MW(), "strst_memwr");
        n_rst = 1;
        step(0, Z(), "strst_reset_zero");
        n_rst = 0;
        step(0, F(0), "strst_after_fetch");
        step(1, F(1), "strst_fetch_done");
        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
